// File: rtl/loopback_chan_fifo.sv
// loopback_chan_fifo
// A bank of independent byte FIFOs. It sits in the loopback path of the
// multi-channel CDC top, between the OUT-endpoint bytes and the IN endpoint.
// Channel k uses bits [8k+7:8k] of the packed data buses.
// Each channel has AW+1 bit read and write pointers. The extra top bit tells
// full apart from empty when the address bits are equal.
// The read is combinational from a register array, so the head byte is
// visible in the same cycle that rd_valid_o rises.
// Optional build macro: LOOPBACK_CHAN_FIFO_LEVEL_EN adds the level_o port,
// which gives a registered fill count per channel.
module loopback_chan_fifo #(
   parameter int CHANNELS = 7,
   parameter int DEPTH    = 8,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic [8*CHANNELS-1:0]       wr_data_i,
   input  logic [CHANNELS-1:0]         wr_valid_i,
   output logic [CHANNELS-1:0]         wr_ready_o,
   output logic [8*CHANNELS-1:0]       rd_data_o,
   output logic [CHANNELS-1:0]         rd_valid_o,
   input  logic [CHANNELS-1:0]         rd_ready_i
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
   ,
   output logic [CHANNELS*(AW+1)-1:0]  level_o
`endif
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [AW:0]   r_wp;
         logic [AW:0]   r_rp;
         logic [7:0]    r_mem [DEPTH];
         logic [AW-1:0] w_waddr;
         logic [AW-1:0] w_raddr;
         logic          w_full;
         logic          w_empty;
         logic          w_push;
         logic          w_pop;

         assign w_waddr = r_wp[AW-1:0];
         assign w_raddr = r_rp[AW-1:0];

         // Equal pointers mean empty. Equal addresses with different wrap bits mean full.
         assign w_empty = (r_wp == r_rp);
         assign w_full  = (w_waddr == w_raddr) && (r_wp[AW] != r_rp[AW]);

         // Ready depends only on the pointers. A full FIFO refuses a push
         // even in a cycle that also pops.
         assign w_push = wr_valid_i[gi] && !w_full;
         assign w_pop  = rd_ready_i[gi] && !w_empty;

         assign wr_ready_o[gi]          = !w_full;
         assign rd_valid_o[gi]          = !w_empty;
         assign rd_data_o[gi*8 +: 8]    = r_mem[w_raddr];

         // Pointer update. Reset wins over any push or pop that arrives in the same cycle.
         always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
               r_wp <= '0;
               r_rp <= '0;
            end else begin
               if (w_push) begin
                  r_wp <= r_wp + PTR_ONE;
               end
               if (w_pop) begin
                  r_rp <= r_rp + PTR_ONE;
               end
            end
         end

         // Storage write. Contents survive reset, but a push presented during reset is dropped.
         always_ff @(posedge clk_i) begin
            if (rstn_i && w_push) begin
               r_mem[w_waddr] <= wr_data_i[gi*8 +: 8];
            end
         end

`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
         logic [AW:0] r_level;

         // Fill count. It moves on the same edge as the pointers and always equals wp - rp.
         always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
               r_level <= '0;
            end else if (w_push && !w_pop) begin
               r_level <= r_level + PTR_ONE;
            end else if (w_pop && !w_push) begin
               r_level <= r_level - PTR_ONE;
            end
         end

         assign level_o[gi*(AW+1) +: (AW+1)] = r_level;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_loopback_chan_fifo.sv
// Directed bench for loopback_chan_fifo with 7 channels and a depth of 8.
// Outputs are sampled 1 time unit after the rising edge. New inputs are
// driven at the same moment.
module tb_loopback_chan_fifo;
   localparam int CH    = 7;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic            clk      = 1'b0;
   logic            rstn     = 1'b0;
   logic [8*CH-1:0] wr_data  = '0;
   logic [CH-1:0]   wr_valid = '0;
   logic [CH-1:0]   wr_ready;
   logic [8*CH-1:0] rd_data;
   logic [CH-1:0]   rd_valid;
   logic [CH-1:0]   rd_ready = '0;
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
   logic [CH*(AW+1)-1:0] level;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   loopback_chan_fifo #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .wr_data_i  (wr_data),
      .wr_valid_i (wr_valid),
      .wr_ready_o (wr_ready),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .rd_ready_i (rd_ready)
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
      ,
      .level_o    (level)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         $display("[%0t] %s observed %0h", $time, tag, obs);
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_wr(input int ch, input logic [7:0] d);
      wr_data[ch*8 +: 8] = d;
   endtask

   function automatic logic [7:0] rd_byte(input int ch);
      return rd_data[ch*8 +: 8];
   endfunction

`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
   function automatic logic [AW:0] lvl(input int ch);
      return level[ch*(AW+1) +: (AW+1)];
   endfunction
`endif

   initial begin
      int occ;
      int n_in;
      int n_out;
      logic pending;
      logic push;
      logic pop;

      // ---------------- reset and idle ----------------
      repeat (2) tick();
      rstn = 1'b1;
      tick();
      check("reset_rd_valid", rd_valid, 7'h00);
      check("reset_wr_ready", wr_ready, 7'h7F);
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
      check("reset_level", level, '0);
`endif

      // ---------------- channel 2: fill to full ----------------
      for (int i = 0; i < 8; i++) begin
         check("ch2_fill_ready", wr_ready[2], 1'b1);
         set_wr(2, 8'(8'h11 + i));
         wr_valid[2] = 1'b1;
         tick();
      end
      check("ch2_full_ready", wr_ready[2], 1'b0);
      check("ch2_full_valid", rd_valid[2], 1'b1);
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
      check("ch2_full_level", lvl(2), 4'd8);
`endif
      // A 9th byte is held against a full FIFO. It must not be taken or overwrite anything.
      set_wr(2, 8'h19);
      repeat (3) tick();
      check("ch2_hold_ready", wr_ready[2], 1'b0);
      check("ch2_hold_head", rd_byte(2), 8'h11);
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
      check("ch2_hold_level", lvl(2), 4'd8);
`endif
      // Drain. 0x19 is taken only after the first pop frees a slot.
      rd_ready[2] = 1'b1;
      occ = 8;
      pending = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check("ch2_drain_valid", rd_valid[2], 1'b1);
         check("ch2_drain_data", rd_byte(2), 8'(8'h11 + i));
         check("ch2_drain_ready", wr_ready[2], 32'(occ < DEPTH));
         push = pending && (occ < DEPTH);
         tick();
         occ = occ - 1 + int'(push);
         if (push) pending = 1'b0;
         wr_valid[2] = pending;
      end
      rd_ready[2] = 1'b0;
      check("ch2_empty_valid", rd_valid[2], 1'b0);
      check("ch2_empty_ready", wr_ready[2], 1'b1);

      // ---------------- channel 0: steady 50% fill ----------------
      for (int i = 0; i < 4; i++) begin
         set_wr(0, 8'(8'hA0 + i));
         wr_valid[0] = 1'b1;
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         set_wr(0, 8'(8'hA4 + i));
         wr_valid[0] = 1'b1;
         rd_ready[0] = 1'b1;
         check("ch0_half_data", rd_byte(0), 8'(8'hA0 + i));
         check("ch0_half_ready", wr_ready[0], 1'b1);
         tick();
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
         check("ch0_half_level", lvl(0), 4'd4);
`endif
      end
      wr_valid[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("ch0_tail_data", rd_byte(0), 8'(8'hB4 + i));
         tick();
      end
      rd_ready[0] = 1'b0;
      check("ch0_empty_valid", rd_valid[0], 1'b0);

      // ---------------- channel 6: wrap under random handshakes ----------------
      n_in  = 0;
      n_out = 0;
      for (int cyc = 0; cyc < 3000 && n_out < 100; cyc++) begin
         wr_valid[6] = (n_in < 100) && ($urandom_range(0, 3) != 0);
         set_wr(6, 8'(n_in));
         rd_ready[6] = ($urandom_range(0, 2) != 0);
         occ = n_in - n_out;
         check("ch6_ready", wr_ready[6], 32'(occ < DEPTH));
         check("ch6_valid", rd_valid[6], 32'(occ != 0));
         pop  = (occ != 0) && rd_ready[6];
         push = wr_valid[6] && (occ < DEPTH);
         if (pop) begin
            check("ch6_data", rd_byte(6), 8'(n_out));
            n_out++;
         end
         if (push) n_in++;
         tick();
      end
      wr_valid[6] = 1'b0;
      rd_ready[6] = 1'b0;
      check("ch6_count", n_out, 100);
      check("ch6_empty_valid", rd_valid[6], 1'b0);

      // ---------------- independence: channel 1 fills, channel 3 streams ----------------
      for (int i = 0; i < 12; i++) begin
         wr_valid[1] = (i < 8);
         set_wr(1, 8'(8'hC0 + i));
         wr_valid[3] = 1'b1;
         rd_ready[3] = 1'b1;
         set_wr(3, 8'(8'h30 + i));
         check("ch3_no_stall_ready", wr_ready[3], 1'b1);
         if (i > 0) begin
            check("ch3_stream_valid", rd_valid[3], 1'b1);
            check("ch3_stream_data", rd_byte(3), 8'(8'h30 + i - 1));
         end
         tick();
      end
      wr_valid[1] = 1'b0;
      wr_valid[3] = 1'b0;
      check("ch1_full_ready", wr_ready[1], 1'b0);
      check("ch3_last_data", rd_byte(3), 8'h3B);
      tick();
      rd_ready[3] = 1'b0;
      check("ch3_empty_valid", rd_valid[3], 1'b0);
      rd_ready[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("ch1_data", rd_byte(1), 8'(8'hC0 + i));
         tick();
      end
      rd_ready[1] = 1'b0;
      check("ch1_empty_valid", rd_valid[1], 1'b0);

      // ---------------- mid-stream reset on channel 4 ----------------
      for (int i = 0; i < 5; i++) begin
         set_wr(4, 8'(8'h40 + i));
         wr_valid[4] = 1'b1;
         tick();
      end
      check("ch4_pre_valid", rd_valid[4], 1'b1);
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
      check("ch4_pre_level", lvl(4), 4'd5);
`endif
      set_wr(4, 8'h55);
      wr_valid[4] = 1'b1;
      rd_ready[4] = 1'b1;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      wr_valid[4] = 1'b0;
      rd_ready[4] = 1'b0;
      check("rst_ch4_valid", rd_valid[4], 1'b0);
      check("rst_ch4_ready", wr_ready[4], 1'b1);
      check("rst_all_valid", rd_valid, 7'h00);
      check("rst_all_ready", wr_ready, 7'h7F);
`ifdef LOOPBACK_CHAN_FIFO_LEVEL_EN
      check("rst_level", level, '0);
`endif
      tick();
      check("rst_idle_valid", rd_valid[4], 1'b0);
      set_wr(4, 8'h66);
      wr_valid[4] = 1'b1;
      tick();
      wr_valid[4] = 1'b0;
      check("post_rst_valid", rd_valid[4], 1'b1);
      check("post_rst_data", rd_byte(4), 8'h66);
      rd_ready[4] = 1'b1;
      tick();
      rd_ready[4] = 1'b0;
      check("post_rst_empty", rd_valid[4], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
